// File: rtl/q88_pkg.sv
// q88_pkg: shared Q8.8 widths, limits, value type and id-width helper
package q88_pkg;
    localparam int Q88_DW = 16;
    localparam int Q88_FRAC = 8;
    localparam logic [15:0] Q88_MAX = 16'h7FFF;
    localparam logic [15:0] Q88_MIN = 16'h8000;
    typedef logic signed [15:0] q88_t;
    function automatic int q88_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/q88_rr_arbiter.sv
// q88_rr_arbiter: round-robin one-hot grant with internal rotating pointer
//   clk, rst : clock, synchronous active-high reset
//   req      : request vector
//   adv      : grant is consumed this cycle when any request is present
//   grant    : one-hot (or zero) grant, first request at or after the pointer
//   id       : encoded index of the granted requester
module q88_rr_arbiter
    import q88_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = q88_idw(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cand [NREQ];
    for (genvar k = 0; k < NREQ; k++) begin : g_cand
        assign cand[k] = IDW'((int'(ptr) + k) % NREQ);
    end
    // scanning from the farthest candidate back lets the nearest one win
    always_comb begin
        grant = '0;
        id = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                grant = {{(NREQ-1){1'b0}}, 1'b1} << cand[k];
                id = cand[k];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (adv && |req)
            ptr <= (int'(id) == NREQ - 1) ? '0 : id + 1'b1;
    end
endmodule

// File: rtl/q88_mul_arbiter.sv
// q88_mul_arbiter: round-robin shared signed Q8.8 multiplier, 2-stage pipeline
//   clk, rst  : clock, synchronous active-high reset
//   req_valid : per-requester operand pair valid
//   req_a/b   : per-requester operands, packed [i*DW +: DW]
//   req_ready : one-hot (or zero) accept
//   rsp_valid/rsp_ready : result handshake
//   rsp_data  : Q8.8 product (wrapped or saturated)
//   rsp_id    : index of the requester that issued the pair
module q88_mul_arbiter
    import q88_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW = Q88_DW,
    parameter int FRAC = Q88_FRAC,
    parameter int SATURATE = 0,
    localparam int IDW = q88_idw(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DW-1:0]      rsp_data,
    output logic [IDW-1:0]     rsp_id
);
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] gid;
    logic s1_valid, s1_adv, s2_adv, ovf;
    logic signed [DW-1:0] s1_a, s1_b;
    logic [IDW-1:0] s1_id;
    logic signed [2*DW-1:0] prod;
    logic [DW-1:0] res;
    assign s2_adv = !rsp_valid || rsp_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign req_ready = (!rst && s1_adv) ? grant : '0;
    q88_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk(clk),
        .rst(rst),
        .req(req_valid),
        .adv(s1_adv && !rst),
        .grant(grant),
        .id(gid)
    );
    assign prod = s1_a * s1_b;
    // bits above the kept window must all match the result sign bit
    assign ovf = !(&prod[2*DW-1:FRAC+DW-1]) && |prod[2*DW-1:FRAC+DW-1];
    assign res = (SATURATE != 0 && ovf)
               ? (prod[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
               : prod[FRAC+DW-1:FRAC];
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a <= '0;
            s1_b <= '0;
            s1_id <= '0;
        end else if (s1_adv) begin
            s1_valid <= |req_ready;
            s1_a <= req_a[int'(gid)*DW +: DW];
            s1_b <= req_b[int'(gid)*DW +: DW];
            s1_id <= gid;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_id <= '0;
        end else if (s2_adv) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_data <= res;
                rsp_id <= s1_id;
            end
        end
    end
endmodule
